// File: rtl/decode_issue_stage_pkg.sv
// Instruction-class encodings and the registered control bundle of the decode/issue stage.
package decode_pkg;

  localparam logic [1:0] FT_REG = 2'b00;
  localparam logic [1:0] FT_MEM = 2'b01;
  localparam logic [1:0] FT_BR  = 2'b10;
  localparam logic [1:0] FT_KER = 2'b11;

  localparam logic [1:0] FC_LOAD  = 2'b00;
  localparam logic [1:0] FC_STORE = 2'b01;
  localparam logic [1:0] FC_MOV   = 2'b10;
  localparam logic [1:0] FC_CMP   = 2'b11;
  // Cache write is the memory-class instruction sharing MOV's funcode.
  localparam logic [1:0] FC_CACHEWR = 2'b10;

  typedef struct packed {
    logic [1:0] funtype;
    logic [1:0] funcode;
    logic       we;
    logic       memrd;
    logic       memwr;
    logic       branch;
    logic       cachewr;
  } decoded_bundle_t;

  localparam decoded_bundle_t BUNDLE_RST = '{funtype: 2'b00, funcode: 2'b00, we: 1'b0,
                                             memrd: 1'b0, memwr: 1'b0, branch: 1'b0,
                                             cachewr: 1'b0};

  function automatic decoded_bundle_t decode_ctrl(input logic [1:0] ft, input logic [1:0] fc);
    decoded_bundle_t b;
    b.funtype = ft;
    b.funcode = fc;
    b.memrd   = (ft == FT_MEM) && (fc == FC_LOAD);
    b.memwr   = (ft == FT_MEM) && (fc == FC_STORE);
    b.cachewr = (ft == FT_MEM) && (fc == FC_CACHEWR);
    b.branch  = (ft == FT_BR);
    b.we      = ((ft == FT_REG) && (fc != FC_CMP)) || b.memrd || b.branch ||
                ((ft == FT_KER) && (fc == 2'b00));
    return b;
  endfunction

endpackage

// File: rtl/decode_issue_stage_if.sv
// Fetch, register-file, release and execute-side signals of the decode/issue stage.
interface decode_issue_stage_if #(
  parameter int BUS = 32,
  parameter int AW  = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [31:0]    instr;
  logic [BUS-1:0] pc_in;
  logic [AW-1:0]  rf_ra_a;
  logic [AW-1:0]  rf_ra_b;
  logic [BUS-1:0] rf_rd_a;
  logic [BUS-1:0] rf_rd_b;
  logic           flush;
  logic           rel_valid;
  logic [AW-1:0]  rel_addr;
  logic           out_valid;
  logic           out_ready;
  logic [1:0]     out_funtype;
  logic [1:0]     out_funcode;
  logic [AW-1:0]  out_rd;
  logic [BUS-1:0] out_opa;
  logic [BUS-1:0] out_opb;
  logic [BUS-1:0] out_str_data;
  logic [BUS-1:0] out_pc;
  logic           out_we;
  logic           out_memrd;
  logic           out_memwr;
  logic           out_branch;
  logic           out_cachewr;

  modport slave (
    input  in_valid, instr, pc_in, rf_rd_a, rf_rd_b, flush, rel_valid, rel_addr, out_ready,
    output in_ready, rf_ra_a, rf_ra_b, out_valid, out_funtype, out_funcode, out_rd,
           out_opa, out_opb, out_str_data, out_pc, out_we, out_memrd, out_memwr,
           out_branch, out_cachewr
  );

  modport master (
    output in_valid, instr, pc_in, rf_rd_a, rf_rd_b, flush, rel_valid, rel_addr, out_ready,
    input  in_ready, rf_ra_a, rf_ra_b, out_valid, out_funtype, out_funcode, out_rd,
           out_opa, out_opb, out_str_data, out_pc, out_we, out_memrd, out_memwr,
           out_branch, out_cachewr
  );
endinterface

// File: rtl/decode_issue_stage_scoreboard.sv
// Per-register in-flight write counters; the hard-zero register is never tracked.
module reg_scoreboard #(
  parameter int NREG  = 16,
  parameter int CNT_W = 2,
  parameter int AW    = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_inc_valid,
  input  logic [AW-1:0] i_inc_addr,
  input  logic          i_rel_valid,
  input  logic [AW-1:0] i_rel_addr,
  input  logic          i_pend_valid,
  input  logic [AW-1:0] i_pend_addr,
  input  logic [AW-1:0] i_qa_addr,
  input  logic [AW-1:0] i_qb_addr,
  input  logic [AW-1:0] i_qd_addr,
  output logic          o_busy_a,
  output logic          o_busy_b,
  output logic          o_sat_d
);
  localparam logic [AW-1:0]    ZERO_REG = AW'(NREG - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt [NREG];
  logic             w_inc;
  logic             w_rel;
  logic [CNT_W-1:0] w_cnt_d;

  assign w_inc   = i_inc_valid && (i_inc_addr != ZERO_REG);
  assign w_rel   = i_rel_valid && (i_rel_addr != ZERO_REG) && (r_cnt[i_rel_addr] != CNT_ZERO);
  assign w_cnt_d = r_cnt[i_qd_addr];

  // A pending write is the held bundle that issues no earlier than this cycle's edge.
  assign o_busy_a = (r_cnt[i_qa_addr] != CNT_ZERO) || (i_pend_valid && (i_pend_addr == i_qa_addr));
  assign o_busy_b = (r_cnt[i_qb_addr] != CNT_ZERO) || (i_pend_valid && (i_pend_addr == i_qb_addr));
  assign o_sat_d  = (w_cnt_d == CNT_MAX) ||
                    (i_pend_valid && (i_pend_addr == i_qd_addr) && (w_cnt_d == CNT_MAX - CNT_ONE));

  // Counter update: issue and release on the same register cancel out.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (rst) begin
        r_cnt[i] <= CNT_ZERO;
      end else if (w_inc && (i_inc_addr == AW'(i)) && !(w_rel && (i_rel_addr == AW'(i)))) begin
        r_cnt[i] <= r_cnt[i] + CNT_ONE;
      end else if (w_rel && (i_rel_addr == AW'(i)) && !(w_inc && (i_inc_addr == AW'(i)))) begin
        r_cnt[i] <= r_cnt[i] - CNT_ONE;
      end else begin
        r_cnt[i] <= r_cnt[i];
      end
    end
  end
endmodule

// File: rtl/decode_issue_stage.sv
// Registered decode stage with valid/ready handshake, RAW scoreboard interlock and flush.
module decode_issue_stage
  import decode_pkg::*;
#(
  parameter int BUS   = 32,
  parameter int NREG  = 16,
  parameter int CNT_W = 2
) (
  input logic                  clk,
  input logic                  rst,
  decode_issue_stage_if.slave  bus
);
  localparam int            AW       = $clog2(NREG);
  localparam logic [AW-1:0] ZERO_REG = AW'(NREG - 1);

  logic [1:0]      w_ft, w_fc;
  logic [AW-1:0]   w_rd, w_rs, w_rx;
  decoded_bundle_t w_ctrl;
  logic            w_src_a_rs, w_opa_zero, w_opb_imm, w_use_a, w_use_b;
  logic [BUS-1:0]  w_imm, w_opa, w_opb, w_str;
  logic            w_busy_a, w_busy_b, w_sat_d, w_hazard;
  logic            w_in_ready, w_accept, w_issue, w_pend;

  logic            r_valid;
  decoded_bundle_t r_ctrl;
  logic [AW-1:0]   r_rd;
  logic [BUS-1:0]  r_opa, r_opb, r_str, r_pc;

  assign w_ft   = bus.instr[31:30];
  assign w_fc   = bus.instr[29:28];
  assign w_rd   = bus.instr[24 +: AW];
  assign w_rs   = bus.instr[20 +: AW];
  assign w_rx   = bus.instr[16 +: AW];
  assign w_ctrl = decode_ctrl(w_ft, w_fc);

  assign w_src_a_rs = ((w_ft == FT_REG) && (w_fc != FC_CMP)) || w_ctrl.memrd || w_ctrl.memwr;
  assign w_opa_zero = ((w_ft == FT_REG) && (w_fc == FC_MOV)) || (w_ft == FT_KER);
  assign w_opb_imm  = bus.instr[0] || w_ctrl.cachewr;
  // Stores read RD through port B so its contents can travel as store data.
  assign bus.rf_ra_a = w_src_a_rs ? w_rs : w_rd;
  assign bus.rf_ra_b = w_ctrl.memwr ? w_rd : w_rx;

  // Immediate selection, zero-extended to the datapath width.
  always_comb begin
    w_imm = {BUS{1'b0}};
    if (w_ctrl.cachewr) begin
      w_imm = BUS'(bus.instr[23:20]);
    end else if (w_ft == FT_REG) begin
      w_imm = BUS'(bus.instr[19:1]);
    end else begin
      w_imm = BUS'(bus.instr[27:0]);
    end
  end

  assign w_opa = w_opa_zero ? {BUS{1'b0}} : bus.rf_rd_a;
  assign w_opb = w_opb_imm ? w_imm : bus.rf_rd_b;

  // Store data is RD's contents from whichever port read RD.
  always_comb begin
    w_str = {BUS{1'b0}};
    if (w_ctrl.memwr) begin
      w_str = bus.rf_rd_b;
    end else if (!w_src_a_rs && !w_opa_zero) begin
      w_str = bus.rf_rd_a;
    end else begin
      w_str = {BUS{1'b0}};
    end
  end

  assign w_use_a  = !w_opa_zero;
  assign w_use_b  = !w_opb_imm || w_ctrl.memwr;
  assign w_pend   = r_valid && r_ctrl.we && (r_rd != ZERO_REG);
  assign w_issue  = w_pend && bus.out_ready && !bus.flush;
  assign w_hazard = (w_use_a && w_busy_a) || (w_use_b && w_busy_b) || (w_ctrl.we && w_sat_d);

  assign w_in_ready = !rst && !w_hazard && (!r_valid || bus.out_ready) && !bus.flush;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign bus.in_ready = w_in_ready;

  reg_scoreboard #(.NREG(NREG), .CNT_W(CNT_W), .AW(AW)) u_sb (
    .clk         (clk),
    .rst         (rst),
    .i_inc_valid (w_issue),
    .i_inc_addr  (r_rd),
    .i_rel_valid (bus.rel_valid),
    .i_rel_addr  (bus.rel_addr),
    .i_pend_valid(w_pend),
    .i_pend_addr (r_rd),
    .i_qa_addr   (bus.rf_ra_a),
    .i_qb_addr   (bus.rf_ra_b),
    .i_qd_addr   (w_rd),
    .o_busy_a    (w_busy_a),
    .o_busy_b    (w_busy_b),
    .o_sat_d     (w_sat_d)
  );

  // Output register: flush kills the held bundle, accept reloads it, consumption empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= BUNDLE_RST;
      r_rd    <= {AW{1'b0}};
      r_opa   <= {BUS{1'b0}};
      r_opb   <= {BUS{1'b0}};
      r_str   <= {BUS{1'b0}};
      r_pc    <= {BUS{1'b0}};
    end else begin
      if (bus.flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid <= 1'b1;
      end else if (bus.out_ready) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
      if (w_accept) begin
        r_ctrl <= w_ctrl;
        r_rd   <= w_rd;
        r_opa  <= w_opa;
        r_opb  <= w_opb;
        r_str  <= w_str;
        r_pc   <= bus.pc_in;
      end
    end
  end

  assign bus.out_valid    = r_valid;
  assign bus.out_funtype  = r_ctrl.funtype;
  assign bus.out_funcode  = r_ctrl.funcode;
  assign bus.out_we       = r_ctrl.we;
  assign bus.out_memrd    = r_ctrl.memrd;
  assign bus.out_memwr    = r_ctrl.memwr;
  assign bus.out_branch   = r_ctrl.branch;
  assign bus.out_cachewr  = r_ctrl.cachewr;
  assign bus.out_rd       = r_rd;
  assign bus.out_opa      = r_opa;
  assign bus.out_opb      = r_opb;
  assign bus.out_str_data = r_str;
  assign bus.out_pc       = r_pc;
endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Registered decode stage for the 32-bit ISA, placed between fetch and execute. Successor to the combinational decoder.
- Parametrised in data width, register count and in-flight write depth.
- Adds three things the old decoder lacks:
  - valid/ready pipeline handshake with a skid-free output register;
  - per-register scoreboard that interlocks RAW hazards, so no forwarding network is required;
  - synchronous flush.
- The register file remains external: the stage drives read addresses and consumes read data in the same cycle.

Parameters:
- BUS, 32, datapath width; immediates are zero-extended to BUS.
- NREG, 16, architectural registers; AW = clog2(NREG). Register NREG-1 is hard zero: never tracked, reads as 0.
- CNT_W, 2, width of each scoreboard counter; max in-flight writes per register = 2^CNT_W-1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  fetch presents instr/pc_in
- in_ready  out  1  stage accepts this cycle
- instr  in  32  [31:30]FUNTYPE [29:28]FUNCODE [27:24]RD [23:20]RS/imm4 [19:16]RX [19:1]imm19 [27:0]imm28 [1]sadd [0]selimm
- pc_in  in  BUS  PC of instr
- rf_ra_a, rf_ra_b  out  AW  register-file read addresses (combinational from instr)
- rf_rd_a, rf_rd_b  in  BUS  read data, same cycle
- flush  in  1  kill the held and incoming instruction
- rel_valid  in  1  a downstream write to rel_addr has retired or been cancelled
- rel_addr  in  AW  register released
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts the bundle
- out_funtype, out_funcode  out  2 each
- out_rd  out  AW
- out_opa, out_opb, out_str_data, out_pc  out  BUS each
- out_we, out_memrd, out_memwr, out_branch, out_cachewr  out  1 each

Behaviour:
- Decode rules are unchanged from the current ISA:
  - we = reg&!CMP | LOAD | branch | kernel00.
  - CMP, LOAD and STORE source selection: reg-WB, LOAD and STORE instructions use RS as source A; all other instructions use RD.
  - MOV and kernel instructions force opa = 0.
  - opb = imm when selimm or cachewr. imm4 is used for cachewr, imm19 for reg type, imm28 otherwise.
  - out_str_data = contents of RD.
- Hazard check: hazard = (scoreboard[srcA] != 0 for a used source) | (scoreboard[srcB] != 0 for a used source) | (we & scoreboard[RD] == max). Zero-register sources are never hazards.
- in_ready = !hazard & (!out_valid | out_ready) & !flush.
- Accept (in_valid & in_ready): the bundle is registered and out_valid = 1 on the next cycle. Latency is 1 cycle.
- out_valid holds and the bundle is stable until out_ready. A new bundle may load in the same cycle the old one is taken.
- Issue: when out_valid & out_ready & out_we & out_rd != zero register, scoreboard[out_rd] += 1.
- Release: rel_valid decrements scoreboard[rel_addr]. rel_valid for the zero register, or for a counter already at 0, is ignored.
- Increment and release of the same register in the same cycle leave the counter unchanged.
- Flush:
  - next cycle out_valid = 0; in_ready = 0 during the flush cycle;
  - the scoreboard is untouched, because the flushed output never issued;
  - an issue in the same cycle as flush is suppressed (flush wins).
- Reset:
  - out_valid = 0, all scoreboard counters = 0, all bundle fields = 0;
  - in_ready = 0 during reset;
  - reset mid-operation discards any held bundle.
- The RS/RX decode runs combinationally from instr even when in_valid = 0. The register-file address ports toggle harmlessly in that case.

Decomposition:
- Package `decode_pkg`:
  - FUNTYPE constants: REG = 00, MEM = 01, BR = 10, KER = 11;
  - FUNCODE constants: CMP = 11, MOV = 10, LOAD = 00, STORE = 01;
  - `decoded_bundle_t` struct.
- Sub-module `reg_scoreboard`: NREG × CNT_W counters with issue/release ports, saturation flag and busy outputs for two read addresses.

Test Plan:
- Reset then `ADD R1,R2,R3` with rf data 5/7 -> one cycle later out_valid = 1, opa = 5, opb = 7, we = 1; after issue, scoreboard[R1] = 1.
- Issue `LOAD R4`, then `ADD R5,R4,R2` -> in_ready = 0 until rel_valid with rel_addr = 4; accepted the cycle after the release.
- out_ready held 0 for 3 cycles -> out bundle is stable, in_ready = 0, no scoreboard change; on the 4th cycle out_ready = 1 takes the bundle and a queued instruction loads in the same cycle.
- Three writes to R6 with CNT_W = 2 -> counter = 3; a fourth writer of R6 stalls; one release unblocks it.
- flush while out_valid = 1 and out_ready = 1 -> no issue, counter unchanged, out_valid = 0 next cycle.
- Same-cycle issue and release on R7 -> counter stays at its value. A `MOV imm` instruction -> opa = 0, no source hazard.
